// File: rtl/vc_rr_scheduler_if.sv
// FIFO-side bus of the VC round-robin scheduler: four ingress VC FIFOs
// (read side) and one shared egress FIFO (write side).
interface vc_rr_scheduler_if #(
  parameter int BW = 6
);
  logic [3:0]      vc_empty;
  logic [4*BW-1:0] vc_data_out;
  logic [3:0]      vc_rd;
  logic            out_full;
  logic            out_almost_full;
  logic            out_wr;
  logic [BW-1:0]   out_data_in;

  // scheduler side
  modport master (
    input  vc_empty, vc_data_out, out_full, out_almost_full,
    output vc_rd, out_wr, out_data_in
  );

  // FIFO / environment side
  modport slave (
    output vc_empty, vc_data_out, out_full, out_almost_full,
    input  vc_rd, out_wr, out_data_in
  );
endinterface

// File: rtl/vc_rr_scheduler.sv
// Weighted round-robin scheduler draining four VC FIFOs into one egress
// FIFO. A grant costs one IDLE bubble; the granted VC then pops up to
// weight words (0 means 1) before the pointer rotates past it. Pops are
// 1-cycle latency, so every egress write trails its pop by exactly one cycle.

// Per-VC slice: read strobe qualification and weight normalisation.
module vc_rr_lane #(
  parameter int WW = 3
) (
  input  logic          sel_i,        // this VC is granted and being served
  input  logic          empty_i,
  input  logic          pop_ok_i,     // egress has room and scheduling enabled
  input  logic [WW-1:0] weight_i,
  output logic          rd_o,
  output logic [WW-1:0] weight_eff_o
);
  assign rd_o         = sel_i & pop_ok_i & ~empty_i;
  assign weight_eff_o = (weight_i == '0) ? WW'(1) : weight_i;
endmodule

module vc_rr_scheduler #(
  parameter int BW = 6,
  parameter int WW = 3
) (
  input  logic                clk,
  input  logic                reset_L,   // active-high synchronous reset
  input  logic                enable,
  input  logic [4*WW-1:0]     weights,
  vc_rr_scheduler_if.master   fifo,
  output logic [1:0]          active_vc,
  output logic                busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, SERVE = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [WW-1:0] credit_q, credit_d;
  logic [1:0]    active_vc_q, active_vc_d;
  logic          rd_pend_q, rd_pend_d;
  logic [1:0]    rd_sel_q, rd_sel_d;

  logic [3:0][WW-1:0] wts;
  logic [3:0][WW-1:0] w_eff;
  logic [3:0][BW-1:0] vdata;
  logic [3:0]         vc_rd_w;
  logic               serving;
  logic               pop_ok;
  logic               pop;
  logic               grant_found;
  logic [1:0]         grant_idx;

  assign wts     = weights;
  assign vdata   = fifo.vc_data_out;
  assign serving = (state_q == SERVE);
  // almost_full gating leaves room for the single word still in flight
  assign pop_ok  = enable & ~fifo.out_full & ~fifo.out_almost_full;
  assign pop     = |vc_rd_w;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    vc_rr_lane #(.WW(WW)) u_lane (
      .sel_i        (serving && (active_vc_q == 2'(i))),
      .empty_i      (fifo.vc_empty[i]),
      .pop_ok_i     (pop_ok),
      .weight_i     (wts[i]),
      .rd_o         (vc_rd_w[i]),
      .weight_eff_o (w_eff[i])
    );
  end

  // First non-empty VC scanning rr_ptr, rr_ptr+1, ... (2-bit index wraps)
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!grant_found && !fifo.vc_empty[rr_ptr_q + 2'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_ptr_q + 2'(k);
      end
    end
  end

  // Next-state: grant in IDLE, burst with credit in SERVE
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    credit_d    = credit_q;
    active_vc_d = active_vc_q;
    case (state_q)
      IDLE: begin
        if (enable && grant_found) begin
          active_vc_d = grant_idx;
          credit_d    = w_eff[grant_idx];   // weight sampled only here
          state_d     = SERVE;
        end
      end
      SERVE: begin
        if (pop) begin
          credit_d = credit_q - WW'(1);
          if (credit_q == WW'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = active_vc_q + 2'd1;
          end
        end else if (fifo.vc_empty[active_vc_q]) begin
          // VC ran dry before its credit did
          state_d  = IDLE;
          rr_ptr_d = active_vc_q + 2'd1;
        end
        // backpressure / enable=0 falls through: hold with credit frozen
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop-to-write pipeline stage
  always_comb begin
    rd_pend_d = pop;
    rd_sel_d  = active_vc_q;
  end

  // State and pipeline registers; reset drops any word in flight
  always_ff @(posedge clk) begin
    if (reset_L) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      credit_q    <= '0;
      active_vc_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_sel_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      active_vc_q <= active_vc_d;
      rd_pend_q   <= rd_pend_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  assign fifo.vc_rd       = vc_rd_w;
  assign fifo.out_wr      = rd_pend_q;
  assign fifo.out_data_in = rd_pend_q ? vdata[rd_sel_q] : '0;
  assign active_vc        = active_vc_q;
  assign busy             = serving;

  // Read strobes are one-hot-or-zero and never target an empty FIFO
  a_rd_onehot : assert property (@(posedge clk) disable iff (reset_L)
    $onehot0(fifo.vc_rd));
  a_rd_nonempty : assert property (@(posedge clk) disable iff (reset_L)
    (fifo.vc_rd & fifo.vc_empty) == 4'b0);

endmodule
